// File: rtl/mem_interconnect.sv
// NUM_CORES-to-one interconnect onto a shared SRAM port and the device bus. Accept is 0 cycles and read data follows 1 cycle later.
// SRAM accesses never stall. Device accesses hold the grant while device_ready is low, and core_ready is the only backpressure.
module mem_interconnect #(
    parameter int NUM_CORES       = 8,
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int DEV_PREFIX_BITS = 6,
    parameter int MEM_ADDR_WIDTH  = 10,
    parameter int ID_WIDTH        = 4,
    parameter int STATIC_ARB      = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_CORES-1:0]                  req_wren,
    input  logic [NUM_CORES-1:0]                  req_rden,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]       req_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]       req_wdata,
    output logic [NUM_CORES-1:0]                  core_ready,
    output logic [NUM_CORES-1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]                 rsp_data,
    output logic [MEM_ADDR_WIDTH-1:0]             mem_addr,
    output logic                                  mem_we,
    output logic [DATA_WIDTH-1:0]                 mem_wdata,
    input  logic [DATA_WIDTH-1:0]                 mem_q,
    output logic [ID_WIDTH-1:0]                   device_core_id,
    output logic                                  device_write_en,
    output logic                                  device_read_en,
    output logic [ADDR_WIDTH-DEV_PREFIX_BITS-1:0] device_addr,
    output logic [DATA_WIDTH-1:0]                 device_data_out,
    input  logic [DATA_WIDTH-1:0]                 device_data_in,
    input  logic                                  device_ready
);
    localparam int IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int DEV_AW = ADDR_WIDTH - DEV_PREFIX_BITS;

    typedef enum logic {ST_IDLE, ST_LOCK} state_t;
    state_t state_q, state_d;

    logic [NUM_CORES-1:0]  req, rr_grant, grant, lock_grant_q, token_q;
    logic [IDX_W-1:0]      ptr_q, sel_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata, dev_rdata;
    logic                  any_grant, sel_wren, sel_rden, dev_sel, dev_access;
    logic                  accept, stall, rsp_from_dev_q;

    assign req = req_wren | req_rden;

    // Scan from farthest to nearest so the nearest requester after ptr_q wins.
    always_comb begin
        int idx;
        logic [NUM_CORES-1:0] cand;
        idx      = 0;
        cand     = '0;
        rr_grant = '0;
        for (int k = NUM_CORES; k >= 1; k--) begin
            idx  = (int'(ptr_q) + k) % NUM_CORES;
            cand = NUM_CORES'(1) << idx;
            if ((req & cand) != '0) rr_grant = cand;
        end
    end

    // Reset masks the grant so every combinational output drops with it.
    always_comb begin
        grant   = '0;
        sel_idx = '0;
        if (!reset) begin
            if (state_q == ST_LOCK)  grant = lock_grant_q;
            else if (STATIC_ARB != 0) grant = token_q & req;
            else                     grant = rr_grant;
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) sel_idx = IDX_W'(i);
        end
    end

    assign any_grant  = |grant;
    assign sel_addr   = req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata  = req_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_wren   = any_grant & req_wren[sel_idx];
    assign sel_rden   = any_grant & req_rden[sel_idx] & ~req_wren[sel_idx];
    assign dev_sel    = &sel_addr[ADDR_WIDTH-1 -: DEV_PREFIX_BITS];
    assign dev_access = dev_sel & (sel_wren | sel_rden);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dev_access && !device_ready) begin
                    stall   = 1'b1;
                    state_d = ST_LOCK;
                end else begin
                    accept = sel_wren | sel_rden;
                end
            end
            ST_LOCK: begin
                if (device_ready) begin
                    accept  = dev_access;
                    state_d = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign core_ready      = accept ? grant : '0;
    assign mem_we          = sel_wren & ~dev_sel;
    assign mem_addr        = sel_addr[MEM_ADDR_WIDTH-1:0];
    assign mem_wdata       = sel_wdata;
    assign device_write_en = sel_wren & dev_sel;
    assign device_read_en  = sel_rden & dev_sel;
    assign device_core_id  = ID_WIDTH'(sel_idx);
    assign device_addr     = sel_addr[DEV_AW-1:0];
    assign device_data_out = sel_wdata;
    assign rsp_data        = (|rsp_valid) ? (rsp_from_dev_q ? dev_rdata : mem_q) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q          <= IDX_W'(NUM_CORES - 1);
            token_q        <= NUM_CORES'(1);
            lock_grant_q   <= '0;
            rsp_valid      <= '0;
            rsp_from_dev_q <= 1'b0;
            dev_rdata      <= '0;
        end else begin
            if (state_q == ST_IDLE) lock_grant_q <= grant;
            if (!stall)  token_q <= {token_q[NUM_CORES-2:0], token_q[NUM_CORES-1]};
            if (accept)  ptr_q   <= sel_idx;
            rsp_valid      <= (accept && sel_rden) ? grant : '0;
            rsp_from_dev_q <= accept & sel_rden & dev_sel;
            if (accept && sel_rden && dev_sel) dev_rdata <= device_data_in;
        end
    end
endmodule

// File: tb/tb_mem_interconnect.sv
// Directed bench: round-robin instance with an SRAM model, plus a static-slot instance.
module tb_mem_interconnect;
    logic         clk;
    logic         reset, st_reset;
    logic [7:0]   req_wren, req_rden, core_ready, rsp_valid;
    logic [127:0] req_addr, req_wdata;
    logic [15:0]  rsp_data, mem_wdata, mem_q, device_data_out, device_data_in;
    logic [9:0]   mem_addr, device_addr;
    logic         mem_we, device_write_en, device_read_en, device_ready;
    logic [3:0]   device_core_id;

    logic [7:0]   st_req_rden, st_core_ready, st_rsp_valid;
    logic [15:0]  st_rsp_data, st_mem_wdata, st_dev_dout;
    logic [9:0]   st_mem_addr, st_dev_addr;
    logic         st_mem_we, st_dev_wen, st_dev_ren;
    logic [3:0]   st_dev_id;

    logic [15:0]  sram [0:1023];
    int checks = 0;
    int errors = 0;

    mem_interconnect u_rr (
        .clk(clk), .reset(reset), .req_wren(req_wren), .req_rden(req_rden),
        .req_addr(req_addr), .req_wdata(req_wdata), .core_ready(core_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_q(mem_q),
        .device_core_id(device_core_id), .device_write_en(device_write_en),
        .device_read_en(device_read_en), .device_addr(device_addr),
        .device_data_out(device_data_out), .device_data_in(device_data_in),
        .device_ready(device_ready)
    );

    mem_interconnect #(.STATIC_ARB(1)) u_st (
        .clk(clk), .reset(st_reset), .req_wren(8'h00), .req_rden(st_req_rden),
        .req_addr(128'h0), .req_wdata(128'h0), .core_ready(st_core_ready),
        .rsp_valid(st_rsp_valid), .rsp_data(st_rsp_data), .mem_addr(st_mem_addr),
        .mem_we(st_mem_we), .mem_wdata(st_mem_wdata), .mem_q(16'h0000),
        .device_core_id(st_dev_id), .device_write_en(st_dev_wen),
        .device_read_en(st_dev_ren), .device_addr(st_dev_addr),
        .device_data_out(st_dev_dout), .device_data_in(16'h0000),
        .device_ready(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        mem_q <= sram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int c, input logic wr, input logic rd,
                           input logic [15:0] a, input logic [15:0] d);
        req_wren[c]          = wr;
        req_rden[c]          = rd;
        req_addr[c*16 +: 16]  = a;
        req_wdata[c*16 +: 16] = d;
    endtask

    initial begin
        reset = 1'b1; st_reset = 1'b1;
        req_wren = '0; req_rden = '0; req_addr = '0; req_wdata = '0;
        st_req_rden = '0; device_ready = 1'b1; device_data_in = '0;
        for (int i = 0; i < 1024; i++) sram[i] = 16'h1000 + 16'(i);
        sram[16'h0010] = 16'hBEEF;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_core_ready", 32'(core_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_dev_wen", 32'(device_write_en), 32'h0);
        chk("rst_dev_ren", 32'(device_read_en), 32'h0);
        chk("rst_dev_id", 32'(device_core_id), 32'h0);
        @(negedge clk); reset = 1'b0;

        // Single SRAM read by core 3
        @(negedge clk); set_req(3, 1'b0, 1'b1, 16'h0010, 16'h0); #1;
        chk("rd_ready", 32'(core_ready), 32'h08);
        chk("rd_mem_we", 32'(mem_we), 32'h0);
        chk("rd_mem_addr", 32'(mem_addr), 32'h010);
        @(negedge clk); set_req(3, 1'b0, 1'b0, 16'h0, 16'h0); #1;
        chk("rd_rsp_valid", 32'(rsp_valid), 32'h08);
        chk("rd_rsp_data", 32'(rsp_data), 32'hBEEF);
        chk("rd_ready_drop", 32'(core_ready), 32'h0);

        // Round-robin fairness from reset
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 8; i++) set_req(i, 1'b0, 1'b1, 16'(i), 16'h0);
        for (int c = 0; c < 9; c++) begin
            #1;
            chk("rr_grant", 32'(core_ready), 32'(1 << (c % 8)));
            if (c > 0) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 32'(1 << ((c - 1) % 8)));
                chk("rr_rsp_data", 32'(rsp_data), 32'h1000 + 32'((c - 1) % 8));
            end
            @(negedge clk);
        end
        req_rden = '0; #1;
        chk("rr_last_valid", 32'(rsp_valid), 32'h01);
        chk("rr_last_data", 32'(rsp_data), 32'h1000);

        // Device write with three wait-states; cores 6 and 7 compete
        @(negedge clk);
        set_req(5, 1'b1, 1'b0, 16'hFC04, 16'h1234);
        set_req(6, 1'b0, 1'b1, 16'h0020, 16'h0);
        set_req(7, 1'b0, 1'b1, 16'h0021, 16'h0);
        for (int c = 0; c < 4; c++) begin
            device_ready = (c == 3);
            #1;
            chk("dw_wen", 32'(device_write_en), 32'h1);
            chk("dw_id", 32'(device_core_id), 32'h5);
            chk("dw_addr", 32'(device_addr), 32'h004);
            chk("dw_dout", 32'(device_data_out), 32'h1234);
            chk("dw_mem_we", 32'(mem_we), 32'h0);
            chk("dw_ready", 32'(core_ready), (c == 3) ? 32'h20 : 32'h0);
            @(negedge clk);
        end
        set_req(5, 1'b0, 1'b0, 16'h0, 16'h0); #1;
        chk("dw_after_wen", 32'(device_write_en), 32'h0);
        chk("dw_next_grant", 32'(core_ready), 32'h40);
        chk("dw_no_rsp", 32'(rsp_valid), 32'h0);
        @(negedge clk); set_req(6, 1'b0, 1'b0, 16'h0, 16'h0); #1;
        chk("c6_rsp_valid", 32'(rsp_valid), 32'h40);
        chk("c6_rsp_data", 32'(rsp_data), 32'h1020);
        chk("c7_grant", 32'(core_ready), 32'h80);
        @(negedge clk); set_req(7, 1'b0, 1'b0, 16'h0, 16'h0); #1;
        chk("c7_rsp_valid", 32'(rsp_valid), 32'h80);
        chk("c7_rsp_data", 32'(rsp_data), 32'h1021);

        // Device read by core 2, SRAM read by core 3 in the following cycle
        @(negedge clk);
        device_ready = 1'b1; device_data_in = 16'hA5A5;
        set_req(2, 1'b0, 1'b1, 16'hFFFF, 16'h0);
        set_req(3, 1'b0, 1'b1, 16'h0010, 16'h0);
        #1;
        chk("dr_ren", 32'(device_read_en), 32'h1);
        chk("dr_id", 32'(device_core_id), 32'h2);
        chk("dr_addr", 32'(device_addr), 32'h3FF);
        chk("dr_ready", 32'(core_ready), 32'h04);
        @(negedge clk); set_req(2, 1'b0, 1'b0, 16'h0, 16'h0); device_data_in = 16'h0000; #1;
        chk("dr_mem_grant", 32'(core_ready), 32'h08);
        chk("dr_rsp_valid", 32'(rsp_valid), 32'h04);
        chk("dr_rsp_data", 32'(rsp_data), 32'hA5A5);
        chk("dr_ren_drop", 32'(device_read_en), 32'h0);
        @(negedge clk); set_req(3, 1'b0, 1'b0, 16'h0, 16'h0); #1;
        chk("dr_mem_valid", 32'(rsp_valid), 32'h08);
        chk("dr_mem_data", 32'(rsp_data), 32'hBEEF);

        // Reset while locked on a device write by core 4
        @(negedge clk);
        device_ready = 1'b0;
        set_req(4, 1'b1, 1'b0, 16'hFC00, 16'h5555);
        set_req(0, 1'b0, 1'b1, 16'h0001, 16'h0);
        #1;
        chk("rl_wen", 32'(device_write_en), 32'h1);
        chk("rl_id", 32'(device_core_id), 32'h4);
        chk("rl_ready", 32'(core_ready), 32'h0);
        @(negedge clk); #1;
        chk("rl_lock_id", 32'(device_core_id), 32'h4);
        chk("rl_lock_ready", 32'(core_ready), 32'h0);
        @(negedge clk); reset = 1'b1; #1;
        chk("rl_rst_ready", 32'(core_ready), 32'h0);
        chk("rl_rst_wen", 32'(device_write_en), 32'h0);
        chk("rl_rst_ren", 32'(device_read_en), 32'h0);
        chk("rl_rst_id", 32'(device_core_id), 32'h0);
        chk("rl_rst_mem_we", 32'(mem_we), 32'h0);
        chk("rl_rst_rsp", 32'(rsp_valid), 32'h0);
        chk("rl_rst_data", 32'(rsp_data), 32'h0);
        @(negedge clk); reset = 1'b0; device_ready = 1'b1; #1;
        chk("rl_first_grant", 32'(core_ready), 32'h01);
        chk("rl_no_rsp", 32'(rsp_valid), 32'h0);
        @(negedge clk); set_req(0, 1'b0, 1'b0, 16'h0, 16'h0); #1;
        chk("rl_c4_grant", 32'(core_ready), 32'h10);
        chk("rl_c0_valid", 32'(rsp_valid), 32'h01);
        chk("rl_c0_data", 32'(rsp_data), 32'h1001);
        @(negedge clk); set_req(4, 1'b0, 1'b0, 16'h0, 16'h0); #1;
        chk("rl_wr_no_rsp", 32'(rsp_valid), 32'h0);

        // Static slot: only core 6 requests from the first cycle after reset
        @(negedge clk); st_reset = 1'b0; st_req_rden[6] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            chk("st_ready", 32'(st_core_ready), (c == 6 || c == 14) ? 32'h40 : 32'h0);
            @(negedge clk);
        end
        st_req_rden = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
